// File: rtl/rv32i_pkg.sv
// Shared RV32I front-end types and constants for the fetch path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rv32i_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Sequential word address; wraps naturally at 32 bits.
    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Instruction buffer of fetch_entry_t with push/pop/flush and occupancy count.
// Latency: an entry pushed at edge N is at the head after edge N.
// Backpressure: push while full is accepted only with a same-cycle pop; flush wins over both.
module ifu_fifo
    import rv32i_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  fetch_entry_t  push_dat,
    input  logic          pop,
    input  logic          flush,
    output fetch_entry_t  head,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !flush && !empty;
    assign do_push = push && !flush && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Pointer and occupancy tracking; DEPTH is a power of two so pointers wrap for free.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Entry storage; contents are qualified by count so they need no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch PC owner: issues IMEM word reads, buffers words with PCs, feeds decode (option FETCH_MISALIGN_CHK_EN).
// Latency: request in first cycle out of reset; with 1-cycle IMEM instr_valid follows two cycles later.
// Backpressure: requests are credit-limited so every in-flight response owns a buffer slot.
module instr_fetch_unit
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_misalign
);

    localparam int              CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0]     DEPTH_W = (CW+1)'(FIFO_DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;

    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic          fifo_full;
    logic          full_unused;
    fetch_entry_t  fifo_head;
    fetch_entry_t  push_dat;

    logic          pop_go;
    logic          push_go;
    logic          rsp_vld;
    logic          issue;
    logic          issue_block;
    logic [CW:0]   in_use;
    logic [31:0]   redirect_tgt;

    // Word alignment is forced on every redirect target; low bits only matter to the checker.
    assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;

`ifdef FETCH_MISALIGN_CHK_EN
    logic misalign_q;

    // Sticky misalign flag: set by a misaligned redirect, cleared only by an aligned one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            misalign_q <= 1'b0;
        end else if (redirect_valid) begin
            misalign_q <= |redirect_pc[1:0];
        end
    end

    assign issue_block    = misalign_q;
    assign fetch_misalign = misalign_q;
`else
    assign issue_block    = 1'b0;
    assign fetch_misalign = 1'b0;
`endif

    // Responses with nothing outstanding are stale traffic from before a reset; ignore them.
    assign rsp_vld = imem_rvalid && (outstanding != '0);

    assign instr_valid = !fifo_empty;
    assign pop_go      = instr_valid && instr_ready;

    // Slots in use = buffered + in flight; a head leaving this cycle frees its slot at the
    // same edge, which is what lets a 2-deep buffer sustain one instruction per cycle.
    assign in_use = {1'b0, fifo_count} + {1'b0, outstanding} - {{CW{1'b0}}, pop_go};
    assign issue  = reset_n && !redirect_valid && !issue_block && (in_use < DEPTH_W);

    // Words still owed to a flushed stream are swallowed; a redirect discards everything.
    assign push_go  = rsp_vld && (drop_cnt == '0) && !redirect_valid;
    assign push_dat = '{pc: resp_pc, instr: imem_rdata};

    assign imem_req   = issue;
    assign imem_addr  = fetch_pc;
    assign instr_data = instr_valid ? fifo_head.instr : NOP_INSTR;
    assign instr_pc   = instr_valid ? fifo_head.pc    : resp_pc;

    assign full_unused = fifo_full;

    // Fetch/response PCs and the in-flight and drop counters; redirect takes priority.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else if (redirect_valid) begin
            fetch_pc    <= redirect_tgt;
            resp_pc     <= redirect_tgt;
            outstanding <= outstanding - CW'(rsp_vld);
            drop_cnt    <= outstanding - CW'(rsp_vld);
        end else begin
            if (issue) begin
                fetch_pc <= next_pc(fetch_pc);
            end
            outstanding <= outstanding + CW'(issue) - CW'(rsp_vld);
            if (rsp_vld) begin
                if (drop_cnt != '0) begin
                    drop_cnt <= drop_cnt - CW'(1);
                end else begin
                    resp_pc <= next_pc(resp_pc);
                end
            end
        end
    end

    ifu_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (push_go),
        .push_dat (push_dat),
        .pop      (pop_go),
        .flush    (redirect_valid),
        .head     (fifo_head),
        .count    (fifo_count),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

endmodule
